ex_seq_ctrl: RTL

Sequencing controller for the EX stage datapath (ALU, branch-target adder, fast mult/div unit). It accepts one instruction at a time from the ID/EX pipeline register and drives the ALU first-cycle flag and the mult/div enables. It holds multi-cycle operations until the EX datapath reports a valid result and the EX/WB stage accepts it. It also provides flush handling and a stuck-operation watchdog.

---
 rtl/ex_seq_pkg.sv | 43 ++++
 rtl/ex_seq_perf_cnt.sv | 44 ++++
 rtl/ex_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ex_seq_pkg.sv
// Shared types and defaults for the EX-stage sequencing controller.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
//
// Contents:
//   ex_seq_state_e  - controller FSM states (IDLE, EXEC)
//   ex_op_class_e   - class of the instruction currently in EX
//   EX_SEQ_MAX_EX_CYCLES_DEF / EX_SEQ_CNT_W_DEF - default watchdog limit and counter width
//   ex_seq_decode_class() - op class decode with multiply taking priority over divide
package ex_seq_pkg;

    // Worst-case divide takes 37 cycles, so the default limit leaves a small margin.
    localparam int unsigned EX_SEQ_MAX_EX_CYCLES_DEF = 40;
    // Counter width must satisfy 2**CNT_W > MAX_EX_CYCLES.
    localparam int unsigned EX_SEQ_CNT_W_DEF         = 6;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } ex_seq_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        MULT = 2'd2,
        DIV  = 2'd3
    } ex_op_class_e;

    // A malformed instruction flagged as both multiply and divide is run as a multiply.
    function automatic ex_op_class_e ex_seq_decode_class(input logic op_mult,
                                                         input logic op_div);
        ex_op_class_e w_class;
        if (op_mult) begin
            w_class = MULT;
        end else if (op_div) begin
            w_class = DIV;
        end else begin
            w_class = ALU;
        end
        return w_class;
    endfunction

endpackage

// File: rtl/ex_seq_perf_cnt.sv
// Saturating stall/retire event counters for the EX sequencing controller.
// Latency: counts are registered, visible the cycle after the event.
// Backpressure: none; pure observers of controller events.
//
// Present only when EX_SEQ_PERF_CNT_EN is defined; otherwise this file is empty.
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   stall_i             - one EXEC cycle ended without a result transfer
//   retire_i            - one result transferred to EX/WB
//   perf_stall_cnt_o    - saturating count of stall_i cycles
//   perf_retire_cnt_o   - saturating count of retire_i cycles
`ifdef EX_SEQ_PERF_CNT_EN
module ex_seq_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        retire_i,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_retire_cnt_o
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_retire_cnt;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (stall_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (retire_i && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o  = r_stall_cnt;
    assign perf_retire_cnt_o = r_retire_cnt;

endmodule
`endif

// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencing controller: accepts one instruction at a time, drives ALU/mult/div controls.
// Latency: result transfer (wb_valid_o) is combinational from ex_valid_i/wb_ready_i; ALU ops retire in their first EXEC cycle.
// Backpressure: holds EXEC with enables asserted while wb_ready_i is low; ex_ready_o only when idle or completing.
//
// Optional feature macro: EX_SEQ_PERF_CNT_EN adds perf_stall_cnt_o / perf_retire_cnt_o.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   id_valid_i, op_mult_i, op_div_i - instruction presented by ID/EX and its class
//   ex_valid_i               - EX datapath result valid
//   wb_ready_i               - EX/WB can take a result
//   flush_i                  - kill the in-flight instruction
//   ex_ready_o               - presented instruction is accepted this cycle
//   alu_instr_first_cycle_o  - first EXEC cycle of the current instruction
//   mult_en_o, div_en_o      - multiplier / divider enables
//   multdiv_ready_id_o       - downstream ready for a mult/div result
//   wb_valid_o               - result transfers to EX/WB this cycle
//   busy_o                   - instruction in flight
//   wdog_err_o               - one-cycle pulse when the watchdog aborts an instruction
module ex_seq_ctrl
    import ex_seq_pkg::*;
#(
    parameter int unsigned MAX_EX_CYCLES = EX_SEQ_MAX_EX_CYCLES_DEF,
    parameter int unsigned CNT_W         = EX_SEQ_CNT_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic        op_mult_i,
    input  logic        op_div_i,
    input  logic        ex_valid_i,
    input  logic        wb_ready_i,
    input  logic        flush_i,
    output logic        ex_ready_o,
    output logic        alu_instr_first_cycle_o,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        multdiv_ready_id_o,
    output logic        wb_valid_o,
    output logic        busy_o,
    output logic        wdog_err_o
`ifdef EX_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_retire_cnt_o
`endif
);

    // Counter value seen during the last allowed EXEC cycle of one instruction.
    localparam logic [CNT_W-1:0] LP_WDOG_LAST = CNT_W'(MAX_EX_CYCLES - 1);

    ex_seq_state_e    r_state;
    ex_seq_state_e    w_state_nxt;
    ex_op_class_e     r_class;
    ex_op_class_e     w_class_nxt;
    logic             r_first;
    logic             w_first_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_wdog_err;
    logic             w_wdog_err_nxt;

    logic             w_exec;
    logic             w_complete;
    logic             w_accept;
    logic             w_wdog_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_class    <= NONE;
            r_first    <= 1'b0;
            r_cnt      <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_class    <= w_class_nxt;
            r_first    <= w_first_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wdog_err <= w_wdog_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_class_nxt    = r_class;
        w_first_nxt    = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_wdog_err_nxt = 1'b0;

        w_exec     = (r_state == EXEC);
        // Flush outranks a result arriving in the same cycle.
        w_complete = w_exec & ex_valid_i & wb_ready_i & ~flush_i;
        ex_ready_o = ~flush_i & (~w_exec | w_complete);
        w_accept   = id_valid_i & ex_ready_o;
        // Abort only when the last allowed cycle also fails to complete; flush takes priority.
        w_wdog_hit = w_exec & ~w_complete & ~flush_i & (r_cnt == LP_WDOG_LAST);

        alu_instr_first_cycle_o = r_first;
        mult_en_o               = w_exec & (r_class == MULT);
        div_en_o                = w_exec & (r_class == DIV);
        multdiv_ready_id_o      = w_exec & wb_ready_i;
        wb_valid_o              = w_complete;
        busy_o                  = w_exec;
        wdog_err_o              = r_wdog_err;

        case (r_state)
            IDLE: begin
                // ex_ready_o is ~flush_i here, so w_accept already excludes flush.
                if (w_accept) begin
                    w_state_nxt = EXEC;
                    w_class_nxt = ex_seq_decode_class(op_mult_i, op_div_i);
                    w_first_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            EXEC: begin
                if (flush_i) begin
                    w_state_nxt = IDLE;
                    w_class_nxt = NONE;
                    w_cnt_nxt   = '0;
                end else if (w_complete) begin
                    if (w_accept) begin
                        // Back-to-back: the next instruction starts without leaving EXEC.
                        w_state_nxt = EXEC;
                        w_class_nxt = ex_seq_decode_class(op_mult_i, op_div_i);
                        w_first_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_class_nxt = NONE;
                    end
                    w_cnt_nxt = '0;
                end else if (w_wdog_hit) begin
                    w_state_nxt    = IDLE;
                    w_class_nxt    = NONE;
                    w_cnt_nxt      = '0;
                    w_wdog_err_nxt = 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_class_nxt = NONE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef EX_SEQ_PERF_CNT_EN
    // A stall is any EXEC cycle that ends without a result transfer, flush cycles included.
    logic w_stall;
    assign w_stall = w_exec & ~w_complete;

    ex_seq_perf_cnt u_perf_cnt (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .stall_i           (w_stall),
        .retire_i          (w_complete),
        .perf_stall_cnt_o  (perf_stall_cnt_o),
        .perf_retire_cnt_o (perf_retire_cnt_o)
    );
`endif

endmodule
